// File: rtl/bcp_clause_scheduler_pkg.sv
// Shared types and default widths for the BCP clause-walk scheduler.
package bcp_clause_scheduler_pkg;

  localparam int CLAUSE_TABLE_BITS = 13;
  localparam int MAX_CLAUSES_BITS  = 12;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_FLUSH = 2'd3
  } sched_state_t;

endpackage

// File: rtl/bcp_clause_scheduler_if.sv
// Control, clause-table RAM and eval-pipeline signals of the clause scheduler.
interface bcp_clause_scheduler_if
  import bcp_clause_scheduler_pkg::*;
#(
  parameter int CT_BITS     = CLAUSE_TABLE_BITS,
  parameter int CLAUSE_BITS = MAX_CLAUSES_BITS
);

  logic                   start;
  logic [CT_BITS-1:0]     start_idx;
  logic [CT_BITS-1:0]     end_idx;
  logic                   abort;
  logic                   ct_rd_en;
  logic [CT_BITS-1:0]     ct_addr;
  logic [CLAUSE_BITS-1:0] ct_q;
  logic                   out_valid;
  logic [CLAUSE_BITS-1:0] out_clause_idx;
  logic                   out_ready;
  logic                   busy;
  logic                   done;
  logic                   flushed;
  logic [CT_BITS:0]       issued_count;

  modport slave (
    input  start, start_idx, end_idx, abort, ct_q, out_ready,
    output ct_rd_en, ct_addr, out_valid, out_clause_idx, busy, done, flushed, issued_count
  );

  modport master (
    output start, start_idx, end_idx, abort, ct_q, out_ready,
    input  ct_rd_en, ct_addr, out_valid, out_clause_idx, busy, done, flushed, issued_count
  );

endinterface

// File: rtl/bcp_clause_scheduler_sync_fifo.sv
// Synchronous FIFO with occupancy count and a synchronous clear; DEPTH must be a power of 2.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_clear,
  input  logic                     i_wr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_rd,
  output logic [WIDTH-1:0]         o_rdata,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_wr;
  logic             w_do_rd;

  assign w_do_wr = i_wr && (r_count != CW'(DEPTH));
  assign w_do_rd = i_rd && (r_count != {CW{1'b0}});

  // pointers wrap naturally because DEPTH is a power of 2
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_do_wr) - CW'(w_do_rd);
    end
  end

  always_ff @(posedge i_clock) begin
    if (w_do_wr) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == {CW{1'b0}});

endmodule

// File: rtl/bcp_clause_scheduler.sv
// Walks a clause-table range, issues fixed-latency RAM reads under a FIFO credit
// and streams the returned clause indices out; abort flushes in-flight reads.
module bcp_clause_scheduler
  import bcp_clause_scheduler_pkg::*;
#(
  parameter int CT_BITS     = CLAUSE_TABLE_BITS,
  parameter int CLAUSE_BITS = MAX_CLAUSES_BITS,
  parameter int RD_LATENCY  = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  bcp_clause_scheduler_if.slave bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  sched_state_t           r_state;
  sched_state_t           w_next_state;
  logic [CT_BITS-1:0]     r_addr;
  logic [CT_BITS-1:0]     r_end;
  logic [CT_BITS:0]       r_issued;
  logic [RD_LATENCY-1:0]  r_pipe;
  logic [RD_LATENCY-1:0]  w_next_pipe;
  logic                   r_done;
  logic                   r_flushed;
  logic                   w_active;
  logic                   w_rd_en;
  logic                   w_last_rd;
  logic                   w_emerge;
  logic                   w_fifo_wr;
  logic                   w_fifo_clear;
  logic                   w_pop;
  logic                   w_out_valid;
  logic                   w_done_set;
  logic                   w_flushed_set;
  logic                   w_fifo_full;
  logic                   w_fifo_empty;
  logic [CLAUSE_BITS-1:0] w_fifo_head;
  logic [CNT_W-1:0]       w_fifo_count;
  logic [CNT_W-1:0]       w_inflight;
  logic [CNT_W-1:0]       w_next_inflight;
  logic [CNT_W-1:0]       w_next_count;
  logic [CNT_W:0]         w_credit_used;

  // reads in flight = valid bits still travelling down the latency pipe
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      w_inflight = w_inflight + CNT_W'(r_pipe[i]);
    end
  end

  always_comb begin
    w_next_pipe    = '0;
    w_next_pipe[0] = w_rd_en;
    for (int i = 1; i < RD_LATENCY; i++) begin
      w_next_pipe[i] = r_pipe[i-1];
    end
  end

  assign w_active      = (r_state == S_ISSUE) || (r_state == S_DRAIN);
  assign w_emerge      = r_pipe[RD_LATENCY-1];
  assign w_credit_used = {1'b0, w_inflight} + {1'b0, w_fifo_count};
  // credit covers every entry that could still land in the FIFO, so it never overflows
  assign w_rd_en       = (r_state == S_ISSUE) && !bus.abort && (r_addr < r_end) &&
                         !w_fifo_full && (w_credit_used < (CNT_W+1)'(FIFO_DEPTH));
  assign w_last_rd     = ((r_addr + CT_BITS'(1)) == r_end);
  assign w_out_valid   = w_active && !bus.abort && !w_fifo_empty;
  assign w_pop         = w_out_valid && bus.out_ready;
  assign w_fifo_wr     = w_active && w_emerge;
  assign w_fifo_clear  = w_active && bus.abort;

  assign w_next_inflight = w_inflight + CNT_W'(w_rd_en) - CNT_W'(w_emerge);
  assign w_next_count    = w_fifo_count + CNT_W'(w_fifo_wr) - CNT_W'(w_pop);

  sync_fifo #(
    .WIDTH (CLAUSE_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_clear (w_fifo_clear),
    .i_wr    (w_fifo_wr),
    .i_wdata (bus.ct_q),
    .i_rd    (w_pop),
    .o_rdata (w_fifo_head),
    .o_count (w_fifo_count),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state  = r_state;
    w_done_set    = 1'b0;
    w_flushed_set = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.start_idx < bus.end_idx) begin
            w_next_state = S_ISSUE;
          end else begin
            w_done_set = 1'b1;
          end
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (bus.abort) begin
          w_next_state = S_FLUSH;
        end else if (w_rd_en && w_last_rd) begin
          w_next_state = S_DRAIN;
        end else begin
          w_next_state = S_ISSUE;
        end
      end
      S_DRAIN: begin
        if (bus.abort) begin
          w_next_state = S_FLUSH;
        end else if ((w_next_inflight == '0) && (w_next_count == '0)) begin
          w_next_state = S_IDLE;
          w_done_set   = 1'b1;
        end else begin
          w_next_state = S_DRAIN;
        end
      end
      S_FLUSH: begin
        if (w_next_inflight == '0) begin
          w_next_state  = S_IDLE;
          w_flushed_set = 1'b1;
        end else begin
          w_next_state = S_FLUSH;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // a start seen while busy never reaches the latch because the state is not IDLE
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_addr    <= '0;
      r_end     <= '0;
      r_issued  <= '0;
      r_pipe    <= '0;
      r_done    <= 1'b0;
      r_flushed <= 1'b0;
    end else begin
      r_pipe    <= w_next_pipe;
      r_done    <= w_done_set;
      r_flushed <= w_flushed_set;
      if ((r_state == S_IDLE) && bus.start) begin
        r_addr   <= bus.start_idx;
        r_end    <= bus.end_idx;
        r_issued <= '0;
      end else if (w_rd_en) begin
        r_addr   <= r_addr + CT_BITS'(1);
        r_issued <= r_issued + (CT_BITS+1)'(1);
      end
    end
  end

  assign bus.ct_rd_en       = w_rd_en;
  assign bus.ct_addr        = r_addr;
  assign bus.out_valid      = w_out_valid;
  assign bus.out_clause_idx = w_out_valid ? w_fifo_head : {CLAUSE_BITS{1'b0}};
  assign bus.busy           = (r_state != S_IDLE);
  assign bus.done           = r_done;
  assign bus.flushed        = r_flushed;
  assign bus.issued_count   = r_issued;

endmodule

// File: tb/tb_bcp_clause_scheduler.sv
// Self-checking bench: scoreboard of expected clause indices plus per-cycle logs
// checked against the cycle-accurate behaviour of the scheduler.
module tb_bcp_clause_scheduler;
  import bcp_clause_scheduler_pkg::*;

  localparam int CT_BITS     = 13;
  localparam int CLAUSE_BITS = 12;
  localparam int RD_LATENCY  = 2;
  localparam int FIFO_DEPTH  = 4;
  localparam int LOGN        = 128;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bcp_clause_scheduler_if #(.CT_BITS(CT_BITS), .CLAUSE_BITS(CLAUSE_BITS)) bus ();

  bcp_clause_scheduler #(
    .CT_BITS     (CT_BITS),
    .CLAUSE_BITS (CLAUSE_BITS),
    .RD_LATENCY  (RD_LATENCY),
    .FIFO_DEPTH  (FIFO_DEPTH)
  ) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  // two-cycle RAM: data = addr + 100, sentinel when no read was issued
  logic [CLAUSE_BITS-1:0] ram_p1 = 12'hEEE;
  always @(posedge clk) begin
    ram_p1   <= bus.ct_rd_en ? CLAUSE_BITS'(bus.ct_addr + 13'd100) : 12'hEEE;
    bus.ct_q <= ram_p1;
  end

  int n_checks = 0;
  int n_errors = 0;
  int rel = 0;
  int n_done, n_flushed, n_xfer;
  logic rd_log   [LOGN];
  logic val_log  [LOGN];
  logic busy_log [LOGN];
  logic done_log [LOGN];
  logic fl_log   [LOGN];
  int   addr_log [LOGN];
  logic [CLAUSE_BITS-1:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic sample();
    if (rel < LOGN) begin
      rd_log[rel]   = bus.ct_rd_en;
      val_log[rel]  = bus.out_valid;
      busy_log[rel] = bus.busy;
      done_log[rel] = bus.done;
      fl_log[rel]   = bus.flushed;
      addr_log[rel] = int'(bus.ct_addr);
    end
    if (bus.done) n_done++;
    if (bus.flushed) n_flushed++;
    if (bus.out_valid && bus.out_ready) begin
      n_xfer++;
      if (exp_q.size() == 0) check("sb_unexpected", 32'(bus.out_clause_idx), 32'hFFFF_FFFF);
      else check("sb_data", 32'(bus.out_clause_idx), 32'(exp_q.pop_front()));
    end
  endtask

  // sample mid-cycle, then move to just after the next rising edge
  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    rel++;
  endtask

  task automatic begin_run(input int s, input int e);
    rel = 0; n_done = 0; n_flushed = 0; n_xfer = 0;
    bus.start     = 1'b1;
    bus.start_idx = CT_BITS'(s);
    bus.end_idx   = CT_BITS'(e);
    tick();
    bus.start = 1'b0;
  endtask

  function automatic int sum_log(input int which, input int lo, input int hi);
    int s = 0;
    for (int k = lo; k <= hi; k++) begin
      case (which)
        0:       s += int'(rd_log[k]);
        1:       s += int'(val_log[k]);
        default: s += int'(busy_log[k]);
      endcase
    end
    return s;
  endfunction

  task automatic run_basic(input bit restart);
    bus.out_ready = 1'b1;
    for (int v = 105; v <= 108; v++) exp_q.push_back(CLAUSE_BITS'(v));
    begin_run(5, 9);
    while (rel < 12) begin
      bus.start = restart && (rel == 2);
      if (restart && rel == 2) begin
        bus.start_idx = 13'd20;
        bus.end_idx   = 13'd30;
      end
      tick();
    end
    bus.start = 1'b0;
    check("basic_rd_c0", 32'(rd_log[0]), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      check("basic_rd", 32'(rd_log[k]), 32'd1);
      check("basic_addr", 32'(addr_log[k]), 32'(4 + k));
    end
    check("basic_rd_after", 32'(sum_log(0, 5, 11)), 32'd0);
    check("basic_valid_c3", 32'(val_log[3]), 32'd0);
    check("basic_valid_4_7", 32'(sum_log(1, 4, 7)), 32'd4);
    check("basic_valid_c8", 32'(val_log[8]), 32'd0);
    check("basic_done_c7", 32'(done_log[7]), 32'd0);
    check("basic_done_c8", 32'(done_log[8]), 32'd1);
    check("basic_done_cnt", 32'(n_done), 32'd1);
    check("basic_busy_c7", 32'(busy_log[7]), 32'd1);
    check("basic_busy_c8", 32'(busy_log[8]), 32'd0);
    check("basic_issued", 32'(bus.issued_count), 32'd4);
    check("basic_xfer", 32'(n_xfer), 32'd4);
    check("basic_sb_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic run_backpressure();
    bus.out_ready = 1'b0;
    for (int v = 100; v <= 109; v++) exp_q.push_back(CLAUSE_BITS'(v));
    begin_run(0, 10);
    while (rel < 10) tick();
    check("bp_stall_reads", 32'(sum_log(0, 0, 9)), 32'd4);
    check("bp_stall_tail", 32'(sum_log(0, 5, 9)), 32'd0);
    bus.out_ready = 1'b1;
    while (n_done == 0 && rel < 80) tick();
    repeat (3) tick();
    check("bp_done_cnt", 32'(n_done), 32'd1);
    check("bp_xfer", 32'(n_xfer), 32'd10);
    check("bp_issued", 32'(bus.issued_count), 32'd10);
    check("bp_sb_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic run_empty();
    bus.out_ready = 1'b1;
    begin_run(7, 7);
    while (rel < 6) tick();
    check("empty_rd", 32'(sum_log(0, 0, 5)), 32'd0);
    check("empty_busy", 32'(sum_log(2, 0, 5)), 32'd0);
    check("empty_done_c1", 32'(done_log[1]), 32'd1);
    check("empty_done_cnt", 32'(n_done), 32'd1);
    check("empty_issued", 32'(bus.issued_count), 32'd0);
  endtask

  task automatic run_abort(input int abort_cyc, input int exp_reads, input int fl_cyc);
    bus.out_ready = 1'b1;
    for (int k = 4; k < abort_cyc; k++) exp_q.push_back(CLAUSE_BITS'(100 + k - 4));
    begin_run(0, 16);
    while (rel < 12) begin
      bus.abort = (rel == abort_cyc);
      tick();
    end
    bus.abort = 1'b0;
    check("abort_reads", 32'(sum_log(0, 0, 11)), 32'(exp_reads));
    check("abort_rd_after", 32'(sum_log(0, abort_cyc, 11)), 32'd0);
    check("abort_valid_after", 32'(sum_log(1, abort_cyc, 11)), 32'd0);
    if (abort_cyc > 4) check("abort_valid_before", 32'(val_log[abort_cyc-1]), 32'd1);
    check("abort_flushed", 32'(fl_log[fl_cyc]), 32'd1);
    check("abort_flushed_cnt", 32'(n_flushed), 32'd1);
    check("abort_no_done", 32'(n_done), 32'd0);
    check("abort_busy_pre", 32'(busy_log[fl_cyc-1]), 32'd1);
    check("abort_busy_post", 32'(busy_log[fl_cyc]), 32'd0);
    check("abort_issued", 32'(bus.issued_count), 32'(exp_reads));
    check("abort_sb_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_en"}, 32'(bus.ct_rd_en), 32'd0);
    check({tag, "_addr"}, 32'(bus.ct_addr), 32'd0);
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_idx"}, 32'(bus.out_clause_idx), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_done"}, 32'(bus.done), 32'd0);
    check({tag, "_flushed"}, 32'(bus.flushed), 32'd0);
    check({tag, "_issued"}, 32'(bus.issued_count), 32'd0);
  endtask

  task automatic run_reset_mid_drain();
    bus.out_ready = 1'b0;
    begin_run(0, 4);
    while (rel < 8) tick();
    check("rst_pre_busy", 32'(bus.busy), 32'd1);
    check("rst_pre_issued", 32'(bus.issued_count), 32'd4);
    #1;
    rst = 1'b1;
    #1;
    check_all_zero("rst_mid");
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.start_idx = '0;
    bus.end_idx   = '0;
    bus.abort     = 1'b0;
    bus.out_ready = 1'b0;
    #2;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    run_basic(1'b0);
    run_basic(1'b1);
    run_backpressure();
    run_empty();
    run_abort(3, 2, 5);
    run_abort(6, 5, 8);
    run_reset_mid_drain();
    run_basic(1'b0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bcp_clause_scheduler.md
Name: bcp_clause_scheduler

Overview:
Parametrised clause-walk engine for BCP. It sits between control and the clause-table RAM / eval pipeline. Given a clause-table range [start_idx, end_idx) for a just-assigned variable, it issues clause-table reads against a fixed-latency RAM, buffers the returned clause indices, and streams them to the evaluation pipeline under ready/valid backpressure. A conflict can abort the walk; the block then flushes all in-flight reads.

Parameters:
CT_BITS, 13, clause-table address width (start/end index width)
CLAUSE_BITS, 12, clause index width (clause-table RAM data width)
RD_LATENCY, 1, clause-table RAM read latency in cycles; legal 1..4
FIFO_DEPTH, 4, return buffer entries; power of 2, must be >= RD_LATENCY+1

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle request; accepted only in IDLE
start_idx  in  CT_BITS  first clause-table entry (inclusive)
end_idx  in  CT_BITS  last clause-table entry (exclusive)
abort  in  1  conflict abort; stops the walk and flushes
ct_rd_en  out  1  clause-table read strobe
ct_addr  out  CT_BITS  clause-table read address
ct_q  in  CLAUSE_BITS  RAM data; valid RD_LATENCY cycles after ct_rd_en
out_valid  out  1  clause index available
out_clause_idx  out  CLAUSE_BITS  FIFO head clause index
out_ready  in  1  consumer accepts; transfer = out_valid & out_ready
busy  out  1  state != IDLE
done  out  1  one-cycle pulse: range fully delivered
flushed  out  1  one-cycle pulse: abort flush complete
issued_count  out  CT_BITS+1  reads issued in current/last run

Behaviour:
- Reset (async, immediate): state IDLE, FIFO empty, in-flight pipe cleared, address/counters 0. All outputs 0.
- States: IDLE, ISSUE, DRAIN, FLUSH.
- IDLE:
  - start latches start_idx/end_idx and clears issued_count.
  - If start_idx < end_idx: go to ISSUE.
  - Otherwise (empty or inverted range): no reads; done pulses in the next cycle and the state stays IDLE.
  - abort is ignored in IDLE. If start and abort arrive in the same IDLE cycle, start is accepted.
- ISSUE:
  - ct_rd_en=1 when addr < end and (inflight + fifo_count) < FIFO_DEPTH, where inflight is the count of reads issued but not yet returned. This credit rule guarantees no FIFO overflow.
  - On each read: addr+1, issued_count+1.
  - After the last read is issued, go to DRAIN.
- Return path:
  - A RD_LATENCY-deep valid shift register tracks reads.
  - When a valid emerges, ct_q is written to the FIFO at that edge.
  - out_valid is asserted from the following cycle; there is no bypass.
  - Order is strictly preserved.
- FIFO: simultaneous write and pop in one cycle is legal and leaves the count unchanged. Pointers wrap modulo FIFO_DEPTH.
- DRAIN: no reads. Go to IDLE on the edge where inflight becomes 0 and the FIFO becomes empty (including a final pop). done=1 in the cycle after that edge; busy=0 in the same cycle.
- abort in ISSUE/DRAIN:
  - In the abort cycle, ct_rd_en and out_valid are forced 0 combinationally, so no transfer occurs.
  - The FIFO is cleared at the edge and the state goes to FLUSH.
- FLUSH: no reads, out_valid=0. Returning RAM data is discarded. Go to IDLE on the edge where inflight becomes 0; flushed=1 for the next cycle. done is not asserted. abort in FLUSH has no further effect.
- start while busy is ignored; latched indices are unchanged.
- Throughput: 1 read per cycle with out_ready held high. Sustained rate is limited only by the FIFO_DEPTH credit.

Decomposition:
- Shared package sysdefs: CLAUSE_TABLE_BITS and MAX_CLAUSES_BITS as parameter defaults, plus a state enum typedef (sched_state_t).
- One sub-module: sync_fifo (parametrised width/depth; count, full, empty, clear). It is reusable by the imply/trace stack refactor.

Test Plan:
(RD_LATENCY=2, FIFO_DEPTH=4; RAM model returns ct_q = addr+100. Cycle 0 is the start cycle.)
- start_idx=5, end_idx=9, out_ready=1 -> ct_addr 5,6,7,8 in cycles 1-4; out_clause_idx 105..108 in cycles 4-7; done in cycle 8; issued_count=4.
- start_idx=0, end_idx=10, out_ready=0 until cycle 10, then 1 -> exactly 4 reads, then ct_rd_en stays low. After ready rises, all 10 indices 100..109 arrive in order with none lost or duplicated; done once.
- start_idx=7, end_idx=7 -> no ct_rd_en; done in cycle 1; busy never high; issued_count=0.
- start_idx=0, end_idx=16, abort in cycle 3 -> no ct_rd_en from cycle 3; out_valid low from cycle 3; flushed in cycle 5; no done; busy low in cycle 5.
- Reset asserted mid-DRAIN -> all outputs 0 without a clock edge. The next start runs normally from IDLE.
- start pulsed again in cycle 2 with different indices -> ignored; the original range completes unchanged.
